// File: rtl/rsa_avm_block_master.sv
// -----------------------------------------------------------------------------
// rsa_avm_block_master
// Avalon-MM master front-end for the RSA modexp engine. On an accepted start it
// reads the exponent d and modulus n, then for each of num_blocks ciphertext
// blocks: reads the block, hands it to the core, takes the core result and
// writes it back to host memory. Only one bus command is outstanding at a time.
//
// Ports
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   start, num_blocks      job request (ignored while busy), block count
//   busy, done             job in progress / one-cycle completion pulse
//   avm_m0_*               Avalon-MM master (address, read, write, writedata,
//                          readdata, readdatavalid, waitrequest)
//   key_d, key_n, key_valid latched key words and their valid flag
//   blk_data/valid/ready   ciphertext block handshake towards the core
//   res_data/valid/ready   result handshake from the core
// -----------------------------------------------------------------------------
module rsa_avm_block_master #(
   parameter int unsigned DATA_W   = 256,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned KEY_BASE = 0,
   parameter int unsigned C_BASE   = 64,
   parameter int unsigned M_BASE   = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [15:0]       num_blocks,
   output logic              busy,
   output logic              done,
   input  logic              avm_m0_waitrequest,
   output logic [ADDR_W-1:0] avm_m0_address,
   output logic              avm_m0_read,
   output logic              avm_m0_write,
   input  logic [DATA_W-1:0] avm_m0_readdata,
   output logic [DATA_W-1:0] avm_m0_writedata,
   input  logic              avm_m0_readdatavalid,
   output logic [DATA_W-1:0] key_d,
   output logic [DATA_W-1:0] key_n,
   output logic              key_valid,
   output logic [DATA_W-1:0] blk_data,
   output logic              blk_valid,
   input  logic              blk_ready,
   input  logic [DATA_W-1:0] res_data,
   input  logic              res_valid,
   output logic              res_ready
);

   typedef enum logic [3:0] {
      S_IDLE, S_RD_D, S_WT_D, S_RD_N, S_WT_N,
      S_RD_C, S_WT_C, S_FEED, S_RES, S_WR_M, S_DONE
   } state_t;

   // Byte stride between consecutive words in host memory.
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

   state_t            state_q, state_d;
   logic [15:0]       nblk_q, nblk_d;
   logic [15:0]       k_q, k_d;
   logic [DATA_W-1:0] d_q, d_d;
   logic [DATA_W-1:0] n_q, n_d;
   logic [DATA_W-1:0] blk_q, blk_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              kv_q, kv_d;
   logic [15:0]       k_inc;
   logic [ADDR_W-1:0] blk_off;

   assign k_inc   = k_q + 16'd1;
   assign blk_off = ADDR_W'(k_q) * STEP;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         nblk_q  <= '0;
         k_q     <= '0;
         d_q     <= '0;
         n_q     <= '0;
         blk_q   <= '0;
         wdata_q <= '0;
         kv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         nblk_q  <= nblk_d;
         k_q     <= k_d;
         d_q     <= d_d;
         n_q     <= n_d;
         blk_q   <= blk_d;
         wdata_q <= wdata_d;
         kv_q    <= kv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      nblk_d  = nblk_q;
      k_d     = k_q;
      d_d     = d_q;
      n_d     = n_q;
      blk_d   = blk_q;
      wdata_d = wdata_q;
      kv_d    = kv_q;
      unique case (state_q)
         S_IDLE: if (start) begin
            nblk_d  = num_blocks;
            k_d     = '0;
            kv_d    = 1'b0;
            state_d = S_RD_D;
         end
         S_RD_D: if (!avm_m0_waitrequest) state_d = S_WT_D;
         S_WT_D: if (avm_m0_readdatavalid) begin
            d_d     = avm_m0_readdata;
            state_d = S_RD_N;
         end
         S_RD_N: if (!avm_m0_waitrequest) state_d = S_WT_N;
         S_WT_N: if (avm_m0_readdatavalid) begin
            n_d     = avm_m0_readdata;
            kv_d    = 1'b1;
            state_d = (nblk_q == 16'd0) ? S_DONE : S_RD_C;
         end
         S_RD_C: if (!avm_m0_waitrequest) state_d = S_WT_C;
         S_WT_C: if (avm_m0_readdatavalid) begin
            blk_d   = avm_m0_readdata;
            state_d = S_FEED;
         end
         S_FEED: if (blk_ready) state_d = S_RES;
         S_RES: if (res_valid) begin
            wdata_d = res_data;
            state_d = S_WR_M;
         end
         S_WR_M: if (!avm_m0_waitrequest) begin
            k_d     = k_inc;
            state_d = (k_inc == nblk_q) ? S_DONE : S_RD_C;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Address is a pure function of registered state, so it only moves on edges.
   always_comb begin
      avm_m0_address = '0;
      case (state_q)
         S_RD_D:  avm_m0_address = ADDR_W'(KEY_BASE);
         S_RD_N:  avm_m0_address = ADDR_W'(KEY_BASE) + STEP;
         S_RD_C:  avm_m0_address = ADDR_W'(C_BASE) + blk_off;
         S_WR_M:  avm_m0_address = ADDR_W'(M_BASE) + blk_off;
         default: avm_m0_address = '0;
      endcase
   end

   assign avm_m0_read      = (state_q == S_RD_D) || (state_q == S_RD_N) || (state_q == S_RD_C);
   assign avm_m0_write     = (state_q == S_WR_M);
   assign avm_m0_writedata = wdata_q;
   assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done             = (state_q == S_DONE);
   assign key_d            = d_q;
   assign key_n            = n_q;
   assign key_valid        = kv_q;
   assign blk_data         = blk_q;
   assign blk_valid        = (state_q == S_FEED);
   assign res_ready        = (state_q == S_RES);

endmodule
